cache_req_arbiter: RTL and testbench

- Multi-channel request front end for the cache simulator.
- Buffers read/write requests from CHANNELS independent requesters in per-channel FIFOs.
- Issues them one at a time to the cache through a registered valid/ready port, using round-robin arbitration.
- Keeps per-channel read/write statistics, and provides a flush/drain mode so a bench can quiesce traffic before sampling results.

---
 rtl/cache_req_arbiter_if.sv | 48 ++++
 rtl/cache_req_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_cache_req_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_req_arbiter_if.sv
// Bundle of the requester, cache and statistics signals of cache_req_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface cache_req_arbiter_if #(
    parameter int CHANNELS     = 4,
    parameter int ADDRESS_SIZE = 32,
    parameter int CNT_WIDTH    = 32
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Requester side: one valid/ready pair per channel.
    logic [CHANNELS-1:0]              in_valid;
    logic [CHANNELS-1:0]              in_rw;
    logic [CHANNELS*ADDRESS_SIZE-1:0] in_address;
    logic [CHANNELS-1:0]              in_ready;

    // Cache side. A request transfers on any rising edge where
    // req_valid && req_ready; while req_valid is high and req_ready is low the
    // payload (rw, address, req_channel) holds stable, and req_valid never
    // drops without a transfer.
    logic                    req_valid;
    logic                    rw;
    logic [ADDRESS_SIZE-1:0] address;
    logic [CW-1:0]           req_channel;
    logic                    req_ready;

    // Drain control and statistics readout.
    logic                    flush;
    logic                    drained;
    logic                    clr_stats;
    logic [CW-1:0]           stat_sel;
    logic [CNT_WIDTH-1:0]    stat_reads;
    logic [CNT_WIDTH-1:0]    stat_writes;

    // Current controller state (0 = RUN, 1 = DRAIN, 2 = DONE).
    logic [1:0]              dbg_state;

    modport slave (
        input  in_valid, in_rw, in_address, req_ready, flush, clr_stats, stat_sel,
        output in_ready, req_valid, rw, address, req_channel, drained,
               stat_reads, stat_writes, dbg_state
    );

    modport master (
        output in_valid, in_rw, in_address, req_ready, flush, clr_stats, stat_sel,
        input  in_ready, req_valid, rw, address, req_channel, drained,
               stat_reads, stat_writes, dbg_state
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// Multi-channel request front end: per-channel FIFOs, round-robin issue into
// a single registered request slot, saturating per-channel read/write
// statistics and a flush/drain controller.
module cache_req_arbiter #(
    parameter int CHANNELS     = 4,
    parameter int ADDRESS_SIZE = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_WIDTH    = 32
) (
    input logic                 clk,
    input logic                 reset,
    cache_req_arbiter_if.slave  bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;

    // Each entry stores {rw, address}; pointers carry one wrap bit.
    logic [ADDRESS_SIZE:0] mem    [CHANNELS][FIFO_DEPTH];
    logic [PW:0]           wr_ptr [CHANNELS];
    logic [PW:0]           rd_ptr [CHANNELS];
    logic [CHANNELS-1:0]   full;
    logic [CHANNELS-1:0]   empty;
    logic [CHANNELS-1:0]   push;
    logic [CHANNELS-1:0]   pop;
    logic [CHANNELS-1:0]   in_ready;
    logic                  all_empty;

    logic [CW-1:0]         ptr;
    logic [CW-1:0]         grant;
    logic                  grant_valid;
    logic                  load;
    logic                  handshake;

    logic                  req_valid;
    logic                  rw;
    logic [ADDRESS_SIZE-1:0] address;
    logic [CW-1:0]         req_channel;
    logic                  drained;

    logic [CNT_WIDTH-1:0]  reads  [CHANNELS];
    logic [CNT_WIDTH-1:0]  writes [CHANNELS];
    logic [CNT_WIDTH-1:0]  stat_reads;
    logic [CNT_WIDTH-1:0]  stat_writes;

    // The output slot frees itself on the same edge it hands off.
    assign load      = !req_valid || bus.req_ready;
    assign handshake = req_valid && bus.req_ready;
    assign all_empty = &empty;

    // FIFO occupancy flags and the per-channel push/pop strobes.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            empty[i]    = (wr_ptr[i] == rd_ptr[i]);
            full[i]     = (wr_ptr[i][PW] != rd_ptr[i][PW]) &&
                          (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]);
            in_ready[i] = (state == RUN) && !full[i];
            push[i]     = bus.in_valid[i] && in_ready[i];
            pop[i]      = load && grant_valid && (grant == CW'(i));
        end
    end

    // Round-robin search over non-empty FIFOs starting at the pointer.
    always_comb begin
        int idx;
        grant       = ptr;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!grant_valid && !empty[idx]) begin
                grant_valid = 1'b1;
                grant       = CW'(idx);
            end
        end
    end

    // FIFO storage writes; contents need no reset since pointers gate them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][PW-1:0]] <= {bus.in_rw[i],
                                              bus.in_address[i*ADDRESS_SIZE +: ADDRESS_SIZE]};
            end
        end
    end

    // FIFO pointer update on push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

    // Output request register and arbitration pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid   <= 1'b0;
            rw          <= 1'b0;
            address     <= '0;
            req_channel <= '0;
            ptr         <= '0;
        end else if (load) begin
            req_valid <= grant_valid;
            if (grant_valid) begin
                {rw, address} <= mem[grant][rd_ptr[grant][PW-1:0]];
                req_channel   <= grant;
                ptr           <= (grant == CW'(CHANNELS - 1)) ? '0 : grant + CW'(1);
            end
        end
    end

    // Saturating statistics; a clear wins over a same-edge increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                reads[i]  <= '0;
                writes[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.clr_stats) begin
                    reads[i]  <= '0;
                    writes[i] <= '0;
                end else if (handshake && req_channel == CW'(i)) begin
                    if (!rw && reads[i] != '1)  reads[i]  <= reads[i] + 1'b1;
                    if (rw && writes[i] != '1)  writes[i] <= writes[i] + 1'b1;
                end
            end
        end
    end

    // Flush controller: stop intake, let the backlog issue, then report drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            drained <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.flush) state <= DRAIN;
                end
                DRAIN: begin
                    if (all_empty && (!req_valid || handshake)) begin
                        state   <= DONE;
                        drained <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.flush) begin
                        state   <= RUN;
                        drained <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    drained <= 1'b0;
                end
            endcase
        end
    end

    // Statistics readout mux; out-of-range selects read as zero.
    always_comb begin
        stat_reads  = '0;
        stat_writes = '0;
        if (32'(bus.stat_sel) < CHANNELS) begin
            stat_reads  = reads[bus.stat_sel];
            stat_writes = writes[bus.stat_sel];
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.req_valid   = req_valid;
    assign bus.rw          = rw;
    assign bus.address     = address;
    assign bus.req_channel = req_channel;
    assign bus.drained     = drained;
    assign bus.stat_reads  = stat_reads;
    assign bus.stat_writes = stat_writes;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_cache_req_arbiter;
    localparam int C    = 4;
    localparam int A    = 32;
    localparam int D    = 4;
    localparam int N    = 4;
    localparam int CW   = 2;
    localparam int MAXC = (1 << N) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    cache_req_arbiter_if #(.CHANNELS(C), .ADDRESS_SIZE(A), .CNT_WIDTH(N)) bus ();

    cache_req_arbiter #(
        .CHANNELS(C), .ADDRESS_SIZE(A), .FIFO_DEPTH(D), .CNT_WIDTH(N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: per-channel request queues, one output slot, counters
    logic [A:0]     mq [C][$];
    int             m_ptr;
    bit             m_valid;
    bit             m_rw;
    logic [A-1:0]   m_addr;
    int             m_ch;
    int             m_reads  [C];
    int             m_writes [C];
    int             m_state;      // 0 running, 1 draining, 2 drained
    bit             m_drained;

    task automatic model_reset();
        for (int i = 0; i < C; i++) begin
            mq[i].delete();
            m_reads[i]  = 0;
            m_writes[i] = 0;
        end
        m_ptr = 0; m_valid = 0; m_rw = 0; m_addr = '0; m_ch = 0;
        m_state = 0; m_drained = 0;
    endtask

    function automatic logic [C-1:0] model_in_ready();
        logic [C-1:0] r;
        for (int i = 0; i < C; i++) r[i] = (m_state == 0) && (mq[i].size() < D);
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic step_model();
        logic [C-1:0] rdy;
        logic [A:0]   e;
        bit           hs, ld, empty_pre, vpre;
        int           g, idx;
        rdy  = model_in_ready();
        vpre = m_valid;
        hs   = m_valid && bus.req_ready;
        ld   = !m_valid || bus.req_ready;
        empty_pre = 1;
        for (int i = 0; i < C; i++) if (mq[i].size() != 0) empty_pre = 0;
        if (bus.clr_stats) begin
            for (int i = 0; i < C; i++) begin m_reads[i] = 0; m_writes[i] = 0; end
        end else if (hs) begin
            if (m_rw) begin if (m_writes[m_ch] < MAXC) m_writes[m_ch]++; end
            else      begin if (m_reads[m_ch]  < MAXC) m_reads[m_ch]++;  end
        end
        if (ld) begin
            g = -1;
            for (int k = 0; k < C; k++) begin
                idx = (m_ptr + k) % C;
                if (g < 0 && mq[idx].size() > 0) g = idx;
            end
            if (g >= 0) begin
                e = mq[g].pop_front();
                m_valid = 1; m_rw = e[A]; m_addr = e[A-1:0]; m_ch = g;
                m_ptr = (g + 1) % C;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < C; i++)
            if (bus.in_valid[i] && rdy[i])
                mq[i].push_back({bus.in_rw[i], bus.in_address[i*A +: A]});
        case (m_state)
            0: if (bus.flush) m_state = 1;
            1: if (empty_pre && (!vpre || hs)) begin m_state = 2; m_drained = 1; end
            default: if (!bus.flush) begin m_state = 0; m_drained = 0; end
        endcase
    endtask

    // driver tasks
    task automatic idle_inputs();
        bus.in_valid = '0; bus.in_rw = '0; bus.in_address = '0; bus.clr_stats = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        step_model();
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        bus.req_ready = 1'b0; bus.flush = 1'b0; bus.stat_sel = '0;
        reset = 1'b0;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b0;
        #2;
        checks++;
        if (bus.req_valid !== 1'b0 || bus.rw !== 1'b0 || bus.address !== '0 ||
            bus.req_channel !== '0 || bus.drained !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b rw=%b addr=%h ch=%0d drained=%b required all zero",
                     bus.req_valid, bus.rw, bus.address, bus.req_channel, bus.drained);
        end
        checks++;
        if (bus.in_ready !== 4'hF) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1111", bus.in_ready);
        end
        for (int s = 0; s < C; s++) begin
            bus.stat_sel = CW'(s);
            #1;
            checks++;
            if (bus.stat_reads !== '0 || bus.stat_writes !== '0) begin
                failures++;
                $display("FAIL reset_stats ch%0d: got r=%0d w=%0d required 0/0",
                         s, bus.stat_reads, bus.stat_writes);
            end
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        bus.req_ready = 1'b1;
        bus.in_valid = 4'b0001; bus.in_rw = 4'b0000;
        bus.in_address[0 +: A] = 32'h0000_1000;
        cycle();
        idle_inputs();
        checks++;
        if (bus.req_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_not_fallthrough: got req_valid=%b required 0", bus.req_valid);
        end
        cycle();
        checks++;
        if (bus.req_valid !== 1'b1 || bus.address !== 32'h1000 || bus.rw !== 1'b0 ||
            bus.req_channel !== 2'd0) begin
            failures++;
            $display("FAIL single_issue: got valid=%b addr=%h rw=%b ch=%0d required 1/1000/0/0",
                     bus.req_valid, bus.address, bus.rw, bus.req_channel);
        end
        cycle();
        bus.stat_sel = 2'd0;
        #1;
        checks++;
        if (bus.stat_reads !== 4'd1 || bus.stat_writes !== 4'd0 || bus.req_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_stats: got r=%0d w=%0d valid=%b required 1/0/0",
                     bus.stat_reads, bus.stat_writes, bus.req_valid);
        end
    endtask

    task automatic test_round_robin();
        int obs[$];
        int first, last;
        apply_reset();
        bus.req_ready = 1'b1;
        first = -1; last = -1;
        for (int t = 0; t < 14; t++) begin
            idle_inputs();
            if (t < 2) begin
                bus.in_valid = 4'hF;
                for (int i = 0; i < C; i++) bus.in_address[i*A +: A] = 32'(t * 16 + i);
            end
            cycle();
            if (bus.req_valid === 1'b1) begin
                obs.push_back(int'(bus.req_channel));
                if (first < 0) first = t;
                last = t;
            end
        end
        checks++;
        if (obs.size() != 8 || last - first != 7) begin
            failures++;
            $display("FAIL rr_count: got %0d valid cycles spanning %0d required 8 spanning 8",
                     obs.size(), last - first + 1);
        end
        for (int k = 0; k < 8 && k < obs.size(); k++) begin
            checks++;
            if (obs[k] != k % 4) begin
                failures++;
                $display("FAIL rr_order[%0d]: got ch%0d required ch%0d", k, obs[k], k % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        int hs;
        logic [A-1:0] exp_addr;
        apply_reset();
        bus.req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            bus.in_valid = 4'b0100;
            bus.in_rw[2] = k[0];
            bus.in_address[2*A +: A] = 32'(32'h200 + 4 * k);
            cycle();
        end
        idle_inputs();
        bus.stat_sel = 2'd2;
        for (int t = 0; t < 5; t++) begin
            cycle();
            checks++;
            if (bus.in_ready[2] !== 1'b0 || bus.req_valid !== 1'b1 || bus.address !== 32'h200 ||
                bus.rw !== 1'b0 || bus.req_channel !== 2'd2 ||
                bus.stat_reads !== '0 || bus.stat_writes !== '0) begin
                failures++;
                $display("FAIL hold[%0d]: got rdy2=%b valid=%b addr=%h rw=%b ch=%0d r=%0d w=%0d required 0/1/200/0/2/0/0",
                         t, bus.in_ready[2], bus.req_valid, bus.address, bus.rw, bus.req_channel,
                         bus.stat_reads, bus.stat_writes);
            end
        end
        bus.req_ready = 1'b1;
        hs = 0;
        for (int t = 0; t < 8; t++) begin
            if (bus.req_valid === 1'b1) begin
                exp_addr = 32'(32'h200 + 4 * hs);
                checks++;
                if (bus.address !== exp_addr || t != hs) begin
                    failures++;
                    $display("FAIL release_order[%0d]: got addr=%h at cycle %0d required %h at cycle %0d",
                             hs, bus.address, t, exp_addr, hs);
                end
                hs++;
            end
            cycle();
        end
        checks++;
        if (hs != 5 || bus.stat_reads !== 4'd3 || bus.stat_writes !== 4'd2) begin
            failures++;
            $display("FAIL release_total: got hs=%0d r=%0d w=%0d required 5/3/2",
                     hs, bus.stat_reads, bus.stat_writes);
        end
    endtask

    task automatic test_flush();
        int  hs;
        bit  seen;
        apply_reset();
        bus.req_ready = 1'b1;
        bus.in_valid = 4'b1011;
        cycle();
        idle_inputs();
        bus.flush = 1'b1;
        cycle();
        checks++;
        if (bus.in_ready !== 4'h0) begin
            failures++;
            $display("FAIL flush_in_ready: got %b required 0000", bus.in_ready);
        end
        hs = 0; seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            if (bus.req_valid === 1'b1) hs++;
            cycle();
            if (bus.drained === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || hs != 3) begin
            failures++;
            $display("FAIL flush_drained: got drained=%b after %0d handshakes required 1 after 3",
                     seen, hs);
        end
        bus.flush = 1'b0;
        cycle();
        checks++;
        if (bus.in_ready !== 4'hF || bus.drained !== 1'b0) begin
            failures++;
            $display("FAIL unflush: got in_ready=%b drained=%b required 1111/0",
                     bus.in_ready, bus.drained);
        end
    endtask

    task automatic test_saturation();
        int pushed;
        logic [C-1:0] rdy;
        apply_reset();
        bus.req_ready = 1'b1;
        bus.stat_sel  = 2'd1;
        pushed = 0;
        for (int t = 0; t < 200 && pushed < 17; t++) begin
            idle_inputs();
            rdy = model_in_ready();
            bus.in_valid[1] = 1'b1;
            bus.in_rw[1]    = 1'b1;
            bus.in_address[1*A +: A] = $urandom();
            if (rdy[1]) pushed++;
            cycle();
        end
        idle_inputs();
        repeat (6) cycle();
        checks++;
        if (pushed != 17 || bus.stat_writes !== 4'd15 || bus.stat_reads !== 4'd0) begin
            failures++;
            $display("FAIL saturate: got pushed=%0d w=%0d r=%0d required 17/15/0",
                     pushed, bus.stat_writes, bus.stat_reads);
        end
        bus.in_valid[1] = 1'b1; bus.in_rw[1] = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (bus.req_valid !== 1'b1) begin
            failures++;
            $display("FAIL clr_setup: got req_valid=%b required 1", bus.req_valid);
        end
        bus.clr_stats = 1'b1;
        cycle();
        bus.clr_stats = 1'b0;
        #1;
        checks++;
        if (bus.stat_writes !== 4'd0) begin
            failures++;
            $display("FAIL clr_priority: got w=%0d required 0", bus.stat_writes);
        end
    endtask

    task automatic test_random();
        int sel;
        apply_reset();
        for (int t = 0; t < 2000; t++) begin
            idle_inputs();
            bus.in_valid = 4'($urandom_range(0, 15));
            bus.in_rw    = 4'($urandom_range(0, 15));
            for (int i = 0; i < C; i++) bus.in_address[i*A +: A] = $urandom();
            bus.req_ready = ($urandom_range(0, 3) != 0);
            bus.clr_stats = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 63) == 0) bus.flush = ~bus.flush;
            sel = $urandom_range(0, C - 1);
            bus.stat_sel = CW'(sel);
            cycle();
            checks++;
            if (bus.req_valid !== m_valid) begin
                failures++;
                $display("FAIL rnd_valid t=%0d: got %b required %b", t, bus.req_valid, m_valid);
            end
            if (m_valid) begin
                checks++;
                if ({bus.rw, bus.address, bus.req_channel} !== {m_rw, m_addr, CW'(m_ch)}) begin
                    failures++;
                    $display("FAIL rnd_payload t=%0d: got rw=%b addr=%h ch=%0d required rw=%b addr=%h ch=%0d",
                             t, bus.rw, bus.address, bus.req_channel, m_rw, m_addr, m_ch);
                end
            end
            checks++;
            if (bus.in_ready !== model_in_ready() || bus.drained !== m_drained) begin
                failures++;
                $display("FAIL rnd_ctrl t=%0d: got in_ready=%b drained=%b required %b/%b",
                         t, bus.in_ready, bus.drained, model_in_ready(), m_drained);
            end
            checks++;
            if (bus.stat_reads !== N'(m_reads[sel]) || bus.stat_writes !== N'(m_writes[sel])) begin
                failures++;
                $display("FAIL rnd_stats t=%0d ch%0d: got r=%0d w=%0d required %0d/%0d",
                         t, sel, bus.stat_reads, bus.stat_writes, m_reads[sel], m_writes[sel]);
            end
        end
        idle_inputs();
        bus.flush = 1'b0;
        bus.req_ready = 1'b1;
        repeat (20) cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.req_ready = 1'b0;
        bus.in_valid = 4'hF; bus.in_rw = 4'b0101;
        cycle();
        idle_inputs();
        cycle();
        bus.req_ready = 1'b1;
        cycle();
        bus.req_ready = 1'b0;
        checks++;
        if (bus.req_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_setup: got req_valid=%b required 1", bus.req_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: got req_valid=%b required 0", bus.req_valid);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_ready = 1'b1;
        repeat (3) cycle();
        checks++;
        if (bus.req_valid !== 1'b0 || bus.in_ready !== 4'hF) begin
            failures++;
            $display("FAIL midreset_after: got valid=%b in_ready=%b required 0/1111",
                     bus.req_valid, bus.in_ready);
        end
        for (int s = 0; s < C; s++) begin
            bus.stat_sel = CW'(s);
            #1;
            checks++;
            if (bus.stat_reads !== '0 || bus.stat_writes !== '0) begin
                failures++;
                $display("FAIL midreset_stats ch%0d: got r=%0d w=%0d required 0/0",
                         s, bus.stat_reads, bus.stat_writes);
            end
        end
    endtask

    // test sequence and final report
    initial begin
        idle_inputs();
        bus.req_ready = 1'b0; bus.flush = 1'b0; bus.stat_sel = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
